// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: FSM state encoding, Funct3 size/sign encodings, default
// bus-timeout bound, and small address helpers used by the top level.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // Funct3: bits [1:0] give the size, bit 2 selects zero extension.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_MAX_WAIT = 16;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  // Clears the low address bits that a naturally aligned access of this size cannot use.
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load lane select and sign/zero extension.
// Ports:
//   rdata   - raw 32-bit word from the data bus
//   addr_lo - byte offset of the access within the word
//   funct3  - access size (bits [1:0]) and unsigned flag (bit 2)
//   data    - extended load result
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;
  logic               sign_ext;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sign_ext = ~funct3[2];
    case (funct3[1:0])
      2'b00:   data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      2'b01:   data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a memory-stage load or store into one data-bus
// transaction and stalls the pipeline until it completes.
// Configuration: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// (MisalignedM pulse, no bus request); otherwise the low address bits are
// forced to the access size and the access proceeds.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   ALUResultM, WriteDataM  - effective address, store data
//   MemReadM, MemWriteM     - load / store request
//   Funct3M, FlushM         - size/sign, squash current instruction
//   mem_req/we/addr/wdata/be, mem_gnt/rvalid/rdata - data bus
//   ReadDataM, StallLSU     - extended load data, pipeline freeze
//   MisalignedM, BusErrM    - single-cycle fault pulses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = LSU_MAX_WAIT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic        FlushM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallLSU,
  output logic        MisalignedM,
  output logic        BusErrM
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              flushed_q;
  logic              start, trap_now, cnt_last, timeout, load_done, busy_q, busy_d;
  logic [31:0]       addr_p0, wdata_p0, load_data;
  logic [2:0]        f3_p0;
  logic              we_p0;

  assign start    = (state_q == S_IDLE) && (MemReadM || MemWriteM) && !FlushM;
  assign cnt_last = (cnt_q == CNT_W'(MAX_WAIT - 1));
  assign busy_q   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign busy_d   = (state_d == S_REQ) || (state_d == S_WAIT);

  // Request capture: held stable for the whole bus transaction
  always_ff @(posedge clk) begin
    if (start) begin
      addr_p0  <= {ALUResultM[31:2], align_lo(Funct3M, ALUResultM[1:0])};
      wdata_p0 <= WriteDataM;
      f3_p0    <= Funct3M;
      we_p0    <= MemWriteM;
    end
  end

  lsu_extend u_extend (
    .rdata   (mem_rdata),
    .addr_lo (addr_p0[1:0]),
    .funct3  (f3_p0),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    timeout   = 1'b0;
    load_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = trap_now ? S_DONE : S_REQ;
      S_REQ: begin
        if (FlushM) begin
          state_d = S_IDLE;
        end else if (mem_gnt) begin
          if (we_p0) begin
            state_d = S_DONE;
          end else if (mem_rvalid) begin
            state_d   = S_DONE;
            load_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_last) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end
      end
      S_WAIT: begin
        // A squashed load still drains its response but skips DONE.
        if (mem_rvalid || cnt_last) begin
          if (flushed_q || FlushM) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DONE;
            load_done = mem_rvalid;
            timeout   = !mem_rvalid;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_REQ) && !FlushM;
    mem_we    = (state_q == S_REQ) && we_p0;
    mem_addr  = {addr_p0[31:2], 2'b00};
    StallLSU  = start || busy_q;
    case (f3_p0[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << addr_p0[1:0];
        mem_wdata = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        mem_be    = addr_p0[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata_p0[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_p0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      cnt_q     <= (busy_q && busy_d) ? cnt_q + CNT_W'(1) : '0;
      flushed_q <= (state_q == S_WAIT) && (flushed_q || FlushM);
      BusErrM   <= timeout;
      if (timeout)        ReadDataM <= '0;
      else if (load_done) ReadDataM <= load_data;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap_now = is_misaligned(Funct3M, ALUResultM[1:0]);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mis_q <= 1'b0;
    else          mis_q <= start && trap_now;
  end
  assign MisalignedM = mis_q;
`else
  assign trap_now    = 1'b0;
  assign MisalignedM = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 16, giving the maximum cycles spent in REQ or WAIT before a bus error is declared.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ALUResultM  input  32  effective address, taken from the ALU result.
REQ-005 WriteDataM  input  32  store data (rs2).
REQ-006 MemReadM / MemWriteM  input  1 each  load / store request; never both high.
REQ-007 Funct3M  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 FlushM  input  1  squash the current memory-stage instruction.
REQ-009 mem_req, mem_we  output  1 each; mem_addr  output  32; mem_wdata  output  32; mem_be  output  4  data-bus request.
REQ-010 mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  32  data-bus response.
REQ-011 ReadDataM  output  32  extended load data; StallLSU  output  1  freezes the pipeline; MisalignedM, BusErrM  output  1 each  single-cycle fault pulses.

Function
REQ-012 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-013 In IDLE, when MemReadM or MemWriteM is high and FlushM is low, the FSM SHALL move to REQ and StallLSU SHALL be high in that cycle.
REQ-014 StallLSU SHALL be high combinationally in IDLE with a request, in REQ, and in WAIT, and low in DONE.
REQ-015 In REQ, mem_req SHALL be 1, mem_addr SHALL equal {addr[31:2],2'b00}, and mem_we, mem_be and mem_wdata SHALL be held stable until mem_gnt.
REQ-016 On mem_gnt, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-017 In WAIT, mem_rvalid SHALL capture the extended load data into ReadDataM and move the FSM to DONE; ReadDataM SHALL hold until the next load completes.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE, so the minimum latency is 3 cycles for a store and 4 for a load.
REQ-019 mem_be SHALL be: B = 1<<addr[1:0]; H = 0011 or 1100 by addr[1]; W = 1111.
REQ-020 mem_wdata SHALL replicate the byte or halfword across all lanes.
REQ-021 Loads SHALL select the lane by addr[1:0]; B/H SHALL sign-extend and BU/HU SHALL zero-extend.
REQ-022 An H access with addr[0]=1, or a W access with addr[1:0]!=0, SHALL be misaligned.
REQ-023 FlushM in REQ before grant SHALL drop mem_req and return the FSM to IDLE.
REQ-024 FlushM in WAIT SHALL still wait for mem_rvalid, leave ReadDataM unchanged, and go to IDLE without DONE.
REQ-025 A counter SHALL count the cycles spent in REQ+WAIT; when it reaches MAX_WAIT, BusErrM SHALL pulse, the FSM SHALL go to DONE, and ReadDataM SHALL be 0.
REQ-026 mem_gnt and mem_rvalid arriving in the same REQ cycle SHALL complete the load directly to DONE.

Reset
REQ-027 When reset_n is low, the state SHALL be IDLE, the counter 0, ReadDataM 0, and mem_req, MisalignedM and BusErrM 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it; responses arriving after reset SHALL be ignored while the FSM is in IDLE.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL pulse MisalignedM, issue no bus request, and go IDLE->DONE.
REQ-030 Without LSU_MISALIGN_TRAP_EN, MisalignedM SHALL be tied to 0 and the access SHALL proceed with the low address bits forced to zero for the size.

Structure
REQ-031 A shared package lsu_pkg SHALL hold the FSM state enum, the Funct3 size/sign encodings, and the MAX_WAIT default.
REQ-032 One sub-module, lsu_extend, SHALL be a combinational load lane-select and extension unit.

Verification
REQ-033 SW addr 0x104, data 0xDEADBEEF, gnt on the 2nd REQ cycle -> mem_be=1111, mem_addr=0x104, StallLSU high for 3 cycles.
REQ-034 LB addr 0x203, rdata 0x80FF1234 -> ReadDataM=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-035 LH addr 0x202, rdata 0x8001ABCD -> ReadDataM=0xFFFF8001, mem_be=1100.
REQ-036 LW addr 0x101 with the macro on -> MisalignedM pulse, mem_req never high; with the macro off -> mem_addr=0x100.
REQ-037 Load with rvalid withheld for 16 cycles -> BusErrM pulse, ReadDataM=0, FSM back to IDLE.
REQ-038 FlushM in WAIT, then rvalid with 0x12345678 -> ReadDataM unchanged, no DONE cycle; reset_n low in REQ -> mem_req=0 immediately.
